// File: rtl/edge_detect_unit.sv
// edge_detect_unit: per-lane rise/fall/toggle pulses plus sticky flags; optional 2-flop input synchronizer via EDGE_DET_SYNC_EN
module edge_detect_unit #(
    parameter int WIDTH = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic [WIDTH-1:0] clr,
    output logic [WIDTH-1:0] prev,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] toggle,
    output logic [WIDTH-1:0] rise_seen,
    output logic [WIDTH-1:0] fall_seen
);
    logic [WIDTH-1:0] det_in;
`ifdef EDGE_DET_SYNC_EN
    logic [WIDTH-1:0] s1, s2;
    // two-stage synchronizer ahead of detection
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= RESET_VAL;
            s2 <= RESET_VAL;
        end else begin
            s1 <= in;
            s2 <= s1;
        end
    end
    assign det_in = s2;
`else
    assign det_in = in;
`endif
    // previous sample of the detection input
    always_ff @(posedge clk) begin
        prev <= reset ? RESET_VAL : det_in;
    end
    // edge pulses, suppressed while reset is held
    always_comb begin
        rise   = reset ? '0 : det_in & ~prev;
        fall   = reset ? '0 : ~det_in & prev;
        toggle = rise | fall;
    end
    // sticky flags; a clear wins over a coincident edge
    always_ff @(posedge clk) begin
        if (reset) begin
            rise_seen <= '0;
            fall_seen <= '0;
        end else begin
            rise_seen <= (rise_seen | rise) & ~clr;
            fall_seen <= (fall_seen | fall) & ~clr;
        end
    end
endmodule

// File: tb/tb_edge_detect_unit.sv
// tb_edge_detect_unit: randomized bench for edge_detect_unit against a sample-history reference model
module tb_edge_detect_unit;
    localparam int W = 4;
    localparam logic [W-1:0] RV = 4'b1010;

    logic clk = 1'b0;
    logic reset;
    logic [W-1:0] in, clr, prev, rise, fall, toggle, rise_seen, fall_seen;
    int errors = 0;
    int checks = 0;
    logic [W-1:0] hist[$];
    logic [W-1:0] m_rs, m_fs;

    edge_detect_unit #(.WIDTH(W), .RESET_VAL(RV)) dut (
        .clk(clk), .reset(reset), .in(in), .clr(clr), .prev(prev),
        .rise(rise), .fall(fall), .toggle(toggle),
        .rise_seen(rise_seen), .fall_seen(fall_seen)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic [W-1:0] i, input logic [W-1:0] c, input bit g = 1'b0);
        logic [W-1:0] d, p, er, ef;
        reset = r;
        in = i;
        clr = c;
        @(negedge clk);
`ifdef EDGE_DET_SYNC_EN
        d = hist[$-1];
        p = hist[$-2];
`else
        d = i;
        p = hist[$];
`endif
        er = r ? '0 : d & ~p;
        ef = r ? '0 : ~d & p;
        check("prev", prev, p);
        check("rise", rise, er);
        check("fall", fall, ef);
        check("toggle", toggle, er | ef);
        check("rise_seen", rise_seen, m_rs);
        check("fall_seen", fall_seen, m_fs);
        if (g) begin
            in = ~i;
            #1;
            in = i;
        end
        @(posedge clk);
        if (r) begin
            hist = {RV, RV, RV};
            m_rs = '0;
            m_fs = '0;
        end else begin
            m_rs = (m_rs | er) & ~c;
            m_fs = (m_fs | ef) & ~c;
            hist.push_back(i);
            if (hist.size() > 4) void'(hist.pop_front());
        end
        #1;
    endtask

    initial begin
        reset = 1'b1;
        in = '0;
        clr = '0;
        @(posedge clk);
        #1;
        hist = {RV, RV, RV};
        m_rs = '0;
        m_fs = '0;
        step(1'b1, 4'b0000, 4'b0000);
        step(1'b1, 4'b0000, 4'b0000);
        step(1'b0, 4'b0000, 4'b0000);
        repeat (3) step(1'b0, 4'b1111, 4'b0000);
        step(1'b0, 4'b0101, 4'b0000);
        step(1'b0, 4'b0110, 4'b0000);
        step(1'b0, 4'b0110, 4'b0000);
        step(1'b0, 4'b0000, 4'b0000);
        step(1'b0, 4'b0001, 4'b0001);
        step(1'b0, 4'b0000, 4'b0000);
        step(1'b0, 4'b0001, 4'b0000);
        step(1'b0, 4'b0001, 4'b0000);
        step(1'b1, 4'b1111, 4'b0000);
        step(1'b1, 4'b1111, 4'b0000);
        step(1'b0, 4'b1111, 4'b0000);
        repeat (3) step(1'b0, 4'b1111, 4'b0000, 1'b1);
        repeat (3) step(1'b0, 4'b1111, 4'b0000);
        for (int k = 0; k < 400; k++)
            step($urandom_range(0, 29) == 0, 4'($urandom), 4'($urandom & $urandom & $urandom),
                 $urandom_range(0, 3) == 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
